// File: rtl/instr_register_pkg.sv
// Shared types and default widths for the instruction register / ALU slice.
package instr_register_pkg;

    localparam int unsigned DEFAULT_DEPTH     = 32;
    localparam int unsigned DEFAULT_OPERAND_W = 32;
    localparam int unsigned DEFAULT_RESULT_W  = 2 * DEFAULT_OPERAND_W;
    localparam int unsigned OPCODE_W          = 4;

    typedef enum logic [OPCODE_W-1:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

endpackage

// File: rtl/instr_register_alu_if.sv
// Write/read/clear bus of the instruction register; master drives requests, slave returns read data.
interface instr_register_alu_if
    import instr_register_pkg::*;
#(
    parameter int unsigned DEPTH     = DEFAULT_DEPTH,
    parameter int unsigned OPERAND_W = DEFAULT_OPERAND_W,
    parameter int unsigned RESULT_W  = 2 * OPERAND_W
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned INSTR_W = OPCODE_W + 2 * OPERAND_W;

    logic                        load_en;
    logic [PTR_W-1:0]            write_pointer;
    opcode_t                     opcode;
    logic signed [OPERAND_W-1:0] operand_a;
    logic signed [OPERAND_W-1:0] operand_b;
    logic                        read_en;
    logic [PTR_W-1:0]            read_pointer;
    logic                        clear_en;

    logic                        rd_valid;
    logic                        rd_entry_valid;
    logic [INSTR_W-1:0]          instruction_word;
    logic signed [RESULT_W-1:0]  result;
    logic                        rd_error;
    logic [CNT_W-1:0]            count;

    modport master (
        output load_en, write_pointer, opcode, operand_a, operand_b,
               read_en, read_pointer, clear_en,
        input  rd_valid, rd_entry_valid, instruction_word, result, rd_error, count
    );

    modport slave (
        input  load_en, write_pointer, opcode, operand_a, operand_b,
               read_en, read_pointer, clear_en,
        output rd_valid, rd_entry_valid, instruction_word, result, rd_error, count
    );

endinterface

// File: rtl/instr_alu.sv
// Combinational signed ALU on the write path; operands are sign-extended to RESULT_W so nothing overflows.
module instr_alu
    import instr_register_pkg::*;
#(
    parameter int unsigned OPERAND_W = DEFAULT_OPERAND_W,
    parameter int unsigned RESULT_W  = 2 * OPERAND_W
) (
    input  opcode_t                     opcode,
    input  logic signed [OPERAND_W-1:0] operand_a,
    input  logic signed [OPERAND_W-1:0] operand_b,
    output logic signed [RESULT_W-1:0]  result,
    output logic                        error
);

    logic signed [RESULT_W-1:0] a_ext;
    logic signed [RESULT_W-1:0] b_ext;

    assign a_ext = RESULT_W'(operand_a);
    assign b_ext = RESULT_W'(operand_b);

    // Division by zero yields 0 with the error flag instead of an X result.
    always_comb begin
        result = '0;
        error  = 1'b0;
        case (opcode)
            ZERO:  result = '0;
            PASSA: result = a_ext;
            PASSB: result = b_ext;
            ADD:   result = a_ext + b_ext;
            SUB:   result = a_ext - b_ext;
            MULT:  result = a_ext * b_ext;
            DIV: begin
                if (b_ext == '0) error  = 1'b1;
                else             result = a_ext / b_ext;
            end
            MOD: begin
                if (b_ext == '0) error  = 1'b1;
                else             result = a_ext % b_ext;
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instr_register_alu.sv
// DEPTH-entry instruction register with precomputed ALU results, registered read port,
// live occupancy count and bulk clear.
module instr_register_alu
    import instr_register_pkg::*;
#(
    parameter int unsigned DEPTH     = DEFAULT_DEPTH,
    parameter int unsigned OPERAND_W = DEFAULT_OPERAND_W,
    parameter int unsigned RESULT_W  = 2 * OPERAND_W
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_register_alu_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        opcode_t                     opcode;
        logic signed [OPERAND_W-1:0] operand_a;
        logic signed [OPERAND_W-1:0] operand_b;
    } instr_t;

    typedef struct packed {
        instr_t                     instr;
        logic signed [RESULT_W-1:0] result;
        logic                       error;
    } entry_t;

    entry_t                     mem_q [DEPTH];
    logic [DEPTH-1:0]           valid_q;
    logic [DEPTH-1:0]           valid_nxt;
    logic [CNT_W-1:0]           count_q;
    logic [CNT_W-1:0]           count_nxt;

    logic signed [RESULT_W-1:0] alu_result;
    logic                       alu_error;
    entry_t                     wr_entry;
    entry_t                     rd_entry_c;
    logic                       rd_entry_valid_c;

    logic                       rd_valid_q;
    logic                       rd_entry_valid_q;
    instr_t                     rd_instr_q;
    logic signed [RESULT_W-1:0] rd_result_q;
    logic                       rd_error_q;

    instr_alu #(
        .OPERAND_W (OPERAND_W),
        .RESULT_W  (RESULT_W)
    ) u_alu (
        .opcode    (bus.opcode),
        .operand_a (bus.operand_a),
        .operand_b (bus.operand_b),
        .result    (alu_result),
        .error     (alu_error)
    );

    always_comb begin
        wr_entry                 = '0;
        wr_entry.instr.opcode    = bus.opcode;
        wr_entry.instr.operand_a = bus.operand_a;
        wr_entry.instr.operand_b = bus.operand_b;
        wr_entry.result          = alu_result;
        wr_entry.error           = alu_error;
    end

    // Clear applies first, then the load, so clear+load leaves exactly that entry valid.
    always_comb begin
        valid_nxt = valid_q;
        count_nxt = count_q;
        if (bus.clear_en) begin
            valid_nxt = '0;
            count_nxt = '0;
        end
        if (bus.load_en) begin
            if (!valid_nxt[bus.write_pointer]) count_nxt = count_nxt + CNT_W'(1);
            valid_nxt[bus.write_pointer] = 1'b1;
        end
    end

    // Reads see post-edge state: write-first on address match, clear otherwise.
    always_comb begin
        rd_entry_valid_c = valid_nxt[bus.read_pointer];
        rd_entry_c       = '0;
        if (bus.load_en && (bus.read_pointer == bus.write_pointer)) rd_entry_c = wr_entry;
        else if (rd_entry_valid_c)                                  rd_entry_c = mem_q[bus.read_pointer];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_nxt;
            count_q <= count_nxt;
            if (bus.load_en) mem_q[bus.write_pointer] <= wr_entry;
        end
    end

    // Read data holds between reads; rd_valid is a single-cycle pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q       <= 1'b0;
            rd_entry_valid_q <= 1'b0;
            rd_instr_q       <= '0;
            rd_result_q      <= '0;
            rd_error_q       <= 1'b0;
        end else begin
            rd_valid_q <= bus.read_en;
            if (bus.read_en) begin
                rd_entry_valid_q <= rd_entry_valid_c;
                rd_instr_q       <= rd_entry_c.instr;
                rd_result_q      <= rd_entry_c.result;
                rd_error_q       <= rd_entry_c.error;
            end
        end
    end

    assign bus.rd_valid         = rd_valid_q;
    assign bus.rd_entry_valid   = rd_entry_valid_q;
    assign bus.instruction_word = rd_instr_q;
    assign bus.result           = rd_result_q;
    assign bus.rd_error         = rd_error_q;
    assign bus.count            = count_q;

endmodule

// File: tb/tb_instr_register_alu.sv
// Directed self-checking bench for instr_register_alu: write/read, arithmetic, clear, async reset.
module tb_instr_register_alu;
    import instr_register_pkg::*;

    localparam int unsigned DEPTH     = 32;
    localparam int unsigned OPERAND_W = 32;
    localparam int unsigned RESULT_W  = 64;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    instr_register_alu_if #(.DEPTH(DEPTH), .OPERAND_W(OPERAND_W), .RESULT_W(RESULT_W)) bus ();

    instr_register_alu #(.DEPTH(DEPTH), .OPERAND_W(OPERAND_W), .RESULT_W(RESULT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation still running, want finished");
        $fatal(1);
    end

    task automatic idle();
        bus.load_en = 1'b0; bus.read_en = 1'b0; bus.clear_en = 1'b0;
        bus.write_pointer = '0; bus.read_pointer = '0;
        bus.opcode = ZERO; bus.operand_a = '0; bus.operand_b = '0;
    endtask

    // Drive one write for one cycle; returns just after the following negedge.
    task automatic write_entry(input int ptr, input opcode_t op, input int a, input int b);
        bus.load_en = 1'b1; bus.write_pointer = 5'(ptr);
        bus.opcode = op; bus.operand_a = 32'(a); bus.operand_b = 32'(b);
        @(negedge clk);
        bus.load_en = 1'b0;
    endtask

    // Drive one read; outputs are sampled by the caller at the returned negedge.
    task automatic read_entry(input int ptr);
        bus.read_en = 1'b1; bus.read_pointer = 5'(ptr);
        @(negedge clk);
        bus.read_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %0b want 0", bus.rd_valid); end
        n_cmp++; if (bus.count !== 6'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        reset = 1'b0;
        read_entry(5);
        n_cmp++; if (bus.rd_valid !== 1'b1) begin n_err++; $display("FAIL empty_rd_valid: got %0b want 1", bus.rd_valid); end
        n_cmp++; if (bus.rd_entry_valid !== 1'b0) begin n_err++; $display("FAIL empty_entry_valid: got %0b want 0", bus.rd_entry_valid); end
        n_cmp++; if (bus.instruction_word !== 68'h0) begin n_err++; $display("FAIL empty_iw: got %h want 0", bus.instruction_word); end
        n_cmp++; if (bus.result !== 64'sd0) begin n_err++; $display("FAIL empty_result: got %0d want 0", bus.result); end
        n_cmp++; if (bus.count !== 6'd0) begin n_err++; $display("FAIL empty_count: got %0d want 0", bus.count); end
        @(negedge clk);
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL rd_valid_pulse: got %0b want 0", bus.rd_valid); end
    endtask

    task automatic test_add_mult();
        logic [67:0] exp_iw;
        exp_iw = {ADD, 32'sd7, -32'sd3};
        write_entry(2, ADD, 7, -3);
        read_entry(2);
        n_cmp++; if (bus.result !== 64'sd4) begin n_err++; $display("FAIL add_result: got %0d want 4", bus.result); end
        n_cmp++; if (bus.rd_error !== 1'b0) begin n_err++; $display("FAIL add_error: got %0b want 0", bus.rd_error); end
        n_cmp++; if (bus.rd_entry_valid !== 1'b1) begin n_err++; $display("FAIL add_entry_valid: got %0b want 1", bus.rd_entry_valid); end
        n_cmp++; if (bus.instruction_word !== exp_iw) begin n_err++; $display("FAIL add_iw: got %h want %h", bus.instruction_word, exp_iw); end
        n_cmp++; if (bus.count !== 6'd1) begin n_err++; $display("FAIL add_count: got %0d want 1", bus.count); end
        @(negedge clk);
        n_cmp++; if (bus.rd_valid !== 1'b0 || bus.result !== 64'sd4) begin
            n_err++; $display("FAIL hold: got rd_valid=%0b result=%0d want rd_valid=0 result=4", bus.rd_valid, bus.result);
        end
        write_entry(2, MULT, -65536, 65536);
        read_entry(2);
        n_cmp++; if (bus.result !== -64'sd4294967296) begin n_err++; $display("FAIL mult_result: got %0d want -4294967296", bus.result); end
        n_cmp++; if (bus.count !== 6'd1) begin n_err++; $display("FAIL overwrite_count: got %0d want 1", bus.count); end
    endtask

    task automatic test_div_mod();
        write_entry(0, DIV, -7, 2);
        write_entry(1, MOD, -7, 2);
        write_entry(3, DIV, 9, 0);
        read_entry(0);
        n_cmp++; if (bus.result !== -64'sd3 || bus.rd_error !== 1'b0) begin
            n_err++; $display("FAIL div: got %0d err %0b want -3 err 0", bus.result, bus.rd_error);
        end
        read_entry(1);
        n_cmp++; if (bus.result !== -64'sd1 || bus.rd_error !== 1'b0) begin
            n_err++; $display("FAIL mod: got %0d err %0b want -1 err 0", bus.result, bus.rd_error);
        end
        read_entry(3);
        n_cmp++; if (bus.result !== 64'sd0 || bus.rd_error !== 1'b1) begin
            n_err++; $display("FAIL div_zero: got %0d err %0b want 0 err 1", bus.result, bus.rd_error);
        end
        n_cmp++; if (bus.count !== 6'd4) begin n_err++; $display("FAIL divmod_count: got %0d want 4", bus.count); end
    endtask

    task automatic test_same_addr();
        bus.read_en = 1'b1; bus.read_pointer = 5'd9;
        write_entry(9, SUB, 10, 4);
        bus.read_en = 1'b0;
        n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_entry_valid !== 1'b1) begin
            n_err++; $display("FAIL wfirst_valid: got rd_valid=%0b entry=%0b want 1 1", bus.rd_valid, bus.rd_entry_valid);
        end
        n_cmp++; if (bus.result !== 64'sd6) begin n_err++; $display("FAIL wfirst_result: got %0d want 6", bus.result); end
        n_cmp++; if (bus.count !== 6'd5) begin n_err++; $display("FAIL wfirst_count: got %0d want 5", bus.count); end
    endtask

    task automatic test_fill_clear();
        for (int i = 0; i < 32; i++) write_entry(i, ADD, i, 1);
        n_cmp++; if (bus.count !== 6'd32) begin n_err++; $display("FAIL full_count: got %0d want 32", bus.count); end
        read_entry(31);
        n_cmp++; if (bus.result !== 64'sd32) begin n_err++; $display("FAIL full_last: got %0d want 32", bus.result); end
        bus.clear_en = 1'b1;
        write_entry(4, PASSA, 42, 0);
        bus.clear_en = 1'b0;
        n_cmp++; if (bus.count !== 6'd1) begin n_err++; $display("FAIL clear_load_count: got %0d want 1", bus.count); end
        read_entry(4);
        n_cmp++; if (bus.rd_entry_valid !== 1'b1 || bus.result !== 64'sd42) begin
            n_err++; $display("FAIL clear_load_kept: got entry=%0b result=%0d want 1 42", bus.rd_entry_valid, bus.result);
        end
        read_entry(5);
        n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_entry_valid !== 1'b0 || bus.result !== 64'sd0) begin
            n_err++; $display("FAIL cleared_entry: got valid=%0b entry=%0b result=%0d want 1 0 0", bus.rd_valid, bus.rd_entry_valid, bus.result);
        end
        // Clear together with a read of the surviving entry: read sees post-clear state.
        bus.clear_en = 1'b1;
        read_entry(4);
        bus.clear_en = 1'b0;
        n_cmp++; if (bus.rd_entry_valid !== 1'b0 || bus.result !== 64'sd0) begin
            n_err++; $display("FAIL clear_read: got entry=%0b result=%0d want 0 0", bus.rd_entry_valid, bus.result);
        end
        n_cmp++; if (bus.count !== 6'd0) begin n_err++; $display("FAIL clear_count: got %0d want 0", bus.count); end
    endtask

    task automatic test_async_reset();
        for (int i = 10; i < 20; i++) write_entry(i, PASSB, 0, i);
        bus.read_en = 1'b1; bus.read_pointer = 5'd10;
        @(posedge clk);
        #1;
        n_cmp++; if (bus.rd_valid !== 1'b1 || bus.result !== 64'sd10 || bus.count !== 6'd10) begin
            n_err++; $display("FAIL pre_reset: got valid=%0b result=%0d count=%0d want 1 10 10", bus.rd_valid, bus.result, bus.count);
        end
        #1;
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.rd_valid !== 1'b0 || bus.rd_entry_valid !== 1'b0 || bus.result !== 64'sd0 ||
                     bus.instruction_word !== 68'h0 || bus.rd_error !== 1'b0 || bus.count !== 6'd0) begin
            n_err++; $display("FAIL async_reset: got valid=%0b entry=%0b result=%0d iw=%h count=%0d want all 0",
                              bus.rd_valid, bus.rd_entry_valid, bus.result, bus.instruction_word, bus.count);
        end
        bus.read_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.rd_valid !== 1'b0 || bus.count !== 6'd0) begin
            n_err++; $display("FAIL post_reset: got valid=%0b count=%0d want 0 0", bus.rd_valid, bus.count);
        end
        read_entry(10);
        n_cmp++; if (bus.rd_entry_valid !== 1'b0 || bus.result !== 64'sd0) begin
            n_err++; $display("FAIL post_reset_read: got entry=%0b result=%0d want 0 0", bus.rd_entry_valid, bus.result);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        idle();
        test_reset();
        test_add_mult();
        test_div_mod();
        test_same_addr();
        test_fill_clear();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_register_alu.md
Name: instr_register_alu

Overview:
Parametrised successor to the lab instruction register. It is a DEPTH-entry register file of {opcode, operand_a, operand_b} with a per-entry valid bit. Each write also computes and stores the signed result and an error flag. It adds a registered read port with a valid pulse, a live occupancy count and a bulk clear. It sits between the testbench interface and the scoreboard; results are precomputed so the bench can compare instruction and result in one read.

Parameters:
DEPTH, 32, number of entries (power of 2, >= 2)
OPERAND_W, 32, signed operand width
RESULT_W, 2*OPERAND_W, signed result width (must be >= 2*OPERAND_W)
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
load_en  input  1  write request this cycle
write_pointer  input  PTR_W  write address
opcode  input  opcode_t  operation to store
operand_a  input  OPERAND_W  signed operand A
operand_b  input  OPERAND_W  signed operand B
read_en  input  1  read request this cycle
read_pointer  input  PTR_W  read address
clear_en  input  1  invalidate all entries
rd_valid  output  1  one-cycle pulse; read data valid
rd_entry_valid  output  1  addressed entry held a valid write
instruction_word  output  {opcode_t, OPERAND_W, OPERAND_W}  stored instruction
result  output  RESULT_W  stored signed result
rd_error  output  1  stored entry had div/mod by zero
count  output  PTR_W+1  number of valid entries

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. While reset is asserted, all entries are invalid and storage is zeroed. Outputs are 0 during reset: rd_valid, rd_entry_valid, instruction_word (opcode ZERO), result, rd_error, count.
- Write: when load_en is high at a rising edge, entry[write_pointer] takes opcode, operands, result, error, and valid is set to 1.
  - Overwriting an already valid entry leaves count unchanged.
  - Writing an invalid entry increments count.
- Result arithmetic: combinational from the write inputs, operands signed and sign-extended to RESULT_W.
  - ZERO gives 0.
  - PASSA gives a; PASSB gives b.
  - ADD gives a+b; SUB gives a-b.
  - MULT gives the full product a*b.
  - DIV gives a/b, truncated toward zero.
  - MOD gives a%b, taking the sign of a.
  - DIV or MOD with b==0 stores result 0 and error 1. All other cases store error 0. No overflow is possible at RESULT_W >= 2*OPERAND_W.
- Read: read_en at edge N produces rd_valid=1 during cycle N+1, with outputs registered from entry[read_pointer].
  - rd_valid is 0 when read_en was low.
  - Data outputs hold their last values when no read occurs.
- Read of an invalid entry: rd_valid=1, rd_entry_valid=0, instruction_word/result/rd_error = 0.
- Same-address read and write in one edge: write-first. The read returns the newly written data, with rd_entry_valid=1.
- Clear: clear_en at an edge invalidates all entries and zeroes count; storage contents need not be zeroed.
  - clear_en together with load_en: the load wins for its entry, so that entry is valid and count becomes 1.
  - clear_en together with read_en: the read observes post-clear state, unless the write-first case applies.
- count saturates naturally at DEPTH; no wrap is possible because only DEPTH distinct addresses exist.
- Reset mid-operation: any pending read pulse is cancelled, and rd_valid is 0 in the cycle after reset deasserts unless read_en is sampled.
- Pointers are full-width, so every address is legal; there is no out-of-range case.

Decomposition:
- Shared package instr_register_pkg holds:
  - opcode_t enum (ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD; 4-bit, values 0-7).
  - Default width constants.
- The instruction record is a module-local packed struct, because it depends on parameters.
- One sub-module, instr_alu: purely combinational, parametrised by OPERAND_W and RESULT_W, with outputs result and error. It is instantiated once on the write path.

Test Plan:
- Reset, then read_en at pointer 5: rd_valid pulses 1 cycle later; rd_entry_valid=0; instruction_word=0, result=0; count=0.
- Write ADD a=7 b=-3 at ptr 2, then read ptr 2: result=4, rd_error=0, rd_entry_valid=1, count=1. Rewrite ptr 2 with MULT a=-65536 b=65536: result=-4294967296 (64-bit), count stays 1.
- Write DIV a=-7 b=2 at ptr 0, MOD a=-7 b=2 at ptr 1, DIV a=9 b=0 at ptr 3: results -3, -1, 0; rd_error 0, 0, 1.
- Same-edge write SUB a=10 b=4 and read, both at ptr 9: the next cycle shows result=6 with rd_entry_valid=1.
- Fill all 32 entries, then check count=32. Then clear_en together with load_en at ptr 4: count=1; a read of ptr 4 is valid and a read of ptr 5 is invalid.
- Assert reset asynchronously mid-cycle after 10 writes with read_en high: outputs go to 0 immediately, without waiting for a clock edge; count=0 after release.
